rot_undo_seq: RTL and testbench
===============================

Name: rot_undo_seq

Overview:
Sequential inverse rotator. It takes a 32-bit word that an upstream stage rotated by a known amount and direction, and restores the original word. It rotates the opposite way, at most 2 bit positions per cycle, with one final 1-bit step when the amount is odd. It sits downstream of the combinational rotate stages and uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, data word width in bits.
- AMT_W, 5, width of the rotate-amount field (amounts 0..WIDTH-1).

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, input word and amount are valid.
- in_ready, output, 1, block can accept a request; high only in IDLE.
- in_data, input, WIDTH, rotated word to restore.
- in_amt, input, AMT_W, number of positions the upstream rotation applied.
- in_dir, input, 1, direction of the upstream rotation: 1 = right, 0 = left.
- out_valid, output, 1, restored word is available.
- out_ready, input, 1, consumer accepts out_data.
- out_data, output, WIDTH, restored word.

Behaviour:
- Reset (already decided): one clock, clk; reset rst is synchronous and active-high. While rst is sampled high:
  - state goes to IDLE;
  - out_valid = 0, out_data = 0, in_ready = 1 after reset;
  - remaining-count and direction registers are cleared.
- Reset mid-operation aborts the job. No output is produced for it.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_data into the work register, remaining = in_amt, undo_dir = ~in_dir.
  - Next state is RUN if in_amt != 0. If in_amt == 0, next state is DONE (pass-through).
- RUN:
  - in_ready = 0; one step per cycle.
  - If remaining >= 2: rotate the work register 2 positions in undo_dir, remaining -= 2.
  - If remaining == 1: rotate 1 position in undo_dir, remaining = 0.
  - When the step leaves remaining == 0, next state is DONE.
- DONE:
  - out_valid = 1; out_data holds the work register and is stable while waiting.
  - On out_ready: next state is IDLE and out_valid drops next cycle.
  - out_ready low holds DONE indefinitely.
- Latency: request accepted at edge T gives out_valid high from cycle T+1+ceil(in_amt/2).
  - in_amt = 0 gives T+1.
  - in_amt = 31 gives T+17.
- Rotation convention: right rotate by k gives {x[k-1:0], x[WIDTH-1:k]}. Left rotate by k gives {x[WIDTH-1-k:0], x[WIDTH-1:WIDTH-k]}.
- in_amt >= WIDTH cannot occur with the default AMT_W. If AMT_W is widened, the amount is taken modulo WIDTH on acceptance.
- No overlap between jobs. A new request is accepted at the earliest in the cycle after the out_valid/out_ready handshake.
- in_valid outside IDLE is ignored, and the input is not latched.
- out_valid and in_ready are never high in the same cycle.

Decomposition:
- The shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the WIDTH/AMT_W defaults;
  - the DIR_RIGHT = 1 and DIR_LEFT = 0 constants.
- One sub-module, rot_step: purely combinational. It rotates a WIDTH-bit word by 1 or 2 positions (select input) in either direction, and is instantiated once in the datapath.

Test Plan:
- in_data = 0x048D159E, in_amt = 2, in_dir = 1, accept at T -> out_valid at T+2, out_data = 0x12345678.
- in_data = 0x48D159E0, in_amt = 2, in_dir = 0 -> out_data = 0x12345678 at T+2.
- in_data = 0x80000001, in_amt = 1, in_dir = 1 -> out_data = 0x00000003 at T+2 (odd-amount final 1-bit step).
- in_data = 0x80000000, in_amt = 31, in_dir = 0 -> out_data = 0x00000001 at T+17. in_ready stays low for the whole job.
- in_amt = 0, in_data = 0xDEADBEEF -> out_data = 0xDEADBEEF at T+1. Hold out_ready low 5 cycles: out_valid/out_data stay stable, and in_ready stays 0 with a second in_valid ignored.
- Assert rst for 1 cycle during RUN of an amt = 20 job -> next cycle out_valid = 0, out_data = 0, in_ready = 1. A following amt = 2 job completes correctly.

Source files
------------

// File: rtl/rot_undo_seq_pkg.sv
// Shared types and constants for the sequential inverse rotator.
package rot_undo_seq_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int AMT_W_DEF = 5;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rot_undo_seq_rot_step.sv
// Combinational single step: rotate a word by 1 or 2 positions, left or right.
module rot_step
  import rot_undo_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data,
  input  logic             two,
  input  logic             dir,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] right1;
  logic [WIDTH-1:0] right2;
  logic [WIDTH-1:0] left1;
  logic [WIDTH-1:0] left2;

  assign right1 = {data[0],         data[WIDTH-1:1]};
  assign right2 = {data[1:0],       data[WIDTH-1:2]};
  assign left1  = {data[WIDTH-2:0], data[WIDTH-1]};
  assign left2  = {data[WIDTH-3:0], data[WIDTH-1:WIDTH-2]};

  always_comb begin
    if (dir == DIR_RIGHT) result = two ? right2 : right1;
    else                  result = two ? left2  : left1;
  end

endmodule

// File: rtl/rot_undo_seq.sv
// Sequential inverse rotator: undoes an upstream rotation 2 bits per cycle,
// with a final 1-bit step for odd amounts; valid/ready on both sides.
module rot_undo_seq
  import rot_undo_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [AMT_W-1:0] rem_q,   rem_d;
  logic             dir_q,   dir_d;

  logic             step_two;
  logic [WIDTH-1:0] step_result;
  logic [AMT_W-1:0] amt_mod;

  assign step_two = (rem_q >= AMT_W'(2));
  // Only matters if AMT_W is widened beyond log2(WIDTH).
  assign amt_mod  = AMT_W'(in_amt % WIDTH);

  rot_step #(.WIDTH(WIDTH)) u_rot_step (
    .data   (work_q),
    .two    (step_two),
    .dir    (dir_q),
    .result (step_result)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    if (rst) begin
      // NOTE: the work register is reset too, so out_data reads 0 after reset.
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state_q;
    work_d    = work_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_data;
          rem_d   = amt_mod;
          dir_d   = ~in_dir;
          state_d = (amt_mod != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        work_d = step_result;
        rem_d  = step_two ? (rem_q - AMT_W'(2)) : '0;
        if (rem_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_data = work_q;

endmodule

// File: tb/tb_rot_undo_seq.sv
// Directed self-checking bench for rot_undo_seq.
module tb_rot_undo_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int total = 0;
  int bad   = 0;

  rot_undo_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one job, measures latency from the accept edge, optionally stalls
  // the consumer while offering a second request, then completes the handshake.
  task automatic run_job(input string name, input logic [31:0] data, input logic [4:0] amt,
                         input logic dir, input logic [31:0] exp_data, input int exp_lat,
                         input int hold);
    int   cycles;
    logic busy_ready;
    logic [31:0] held;
    in_data  = data;
    in_amt   = amt;
    in_dir   = dir;
    in_valid = 1'b1;
    check({name, "_ready_idle"}, 32'(in_ready), 32'd1);
    tick();
    in_valid   = 1'b0;
    in_data    = 32'hFFFF_FFFF;
    cycles     = 1;
    busy_ready = 1'b0;
    while (!out_valid && cycles < 40) begin
      if (in_ready) busy_ready = 1'b1;
      tick();
      cycles++;
    end
    check({name, "_latency"}, 32'(cycles), 32'(exp_lat));
    check({name, "_ready_busy"}, 32'(busy_ready), 32'd0);
    check({name, "_data"}, out_data, exp_data);
    check({name, "_excl"}, 32'(in_ready & out_valid), 32'd0);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h5555_AAAA;
      in_amt   = 5'd3;
      tick();
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_data"}, out_data, held);
      check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_drop_valid"}, 32'(out_valid), 32'd0);
    check({name, "_back_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_job("r2",   32'h048D_159E, 5'd2,  1'b1, 32'h1234_5678, 2,  0);
    run_job("l2",   32'h48D1_59E0, 5'd2,  1'b0, 32'h1234_5678, 2,  0);
    run_job("r1",   32'h8000_0001, 5'd1,  1'b1, 32'h0000_0003, 2,  0);
    run_job("l31",  32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 17, 0);
    run_job("r5",   32'h0000_00F0, 5'd5,  1'b1, 32'h0000_1E00, 4,  0);
    run_job("zero", 32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 1,  5);

    // Reset in the middle of a long job aborts it without output.
    in_data  = 32'h0000_FFFF;
    in_amt   = 5'd20;
    in_dir   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", out_data, 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) tick();
    check("abort_no_output", 32'(out_valid), 32'd0);

    run_job("post", 32'h048D_159E, 5'd2, 1'b1, 32'h1234_5678, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
